// File: rtl/bc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bc_pkg
//  Description : Shared types and 7-segment codes for the bulls-and-cows
//                score display sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package bc_pkg;

    // Display sequencer states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHOW_B  = 3'd1,
        SHOW_BN = 3'd2,
        SHOW_C  = 3'd3,
        SHOW_CN = 3'd4,
        WIN_ON  = 3'd5,
        WIN_OFF = 3'd6
    } state_t;

    // Segment codes, bit order {dp,g,f,e,d,c,b,a}, active-high
    localparam logic [7:0] SEG_DASH = 8'h40;
    localparam logic [7:0] SEG_B    = 8'h7C;
    localparam logic [7:0] SEG_C    = 8'h58;
    localparam logic [7:0] SEG_E    = 8'h79;
    localparam logic [7:0] SEG_ALL  = 8'hFF;
    localparam logic [7:0] SEG_OFF  = 8'h00;

    // Digit table 0..4, entry [n] holds the code for digit n
    localparam logic [4:0][7:0] SEG_DIGITS = {8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F};

endpackage : bc_pkg
`default_nettype wire

// File: rtl/bc_seg_encode.sv
`default_nettype none
// ============================================================================
//  Module      : bc_seg_encode
//  Description : Combinational 3-bit score value to 7-segment code. Values
//                above 4 cannot occur in a legal score and show 'E'.
//  Revision    : 1.0 - initial release
// ============================================================================
module bc_seg_encode
    import bc_pkg::*;
(
    input  logic [2:0] value,
    output logic [7:0] seg
);

    // Map legal digits through the table, anything else to 'E'
    always_comb begin
        seg = SEG_E;
        case (value)
            3'd0:    seg = SEG_DIGITS[0];
            3'd1:    seg = SEG_DIGITS[1];
            3'd2:    seg = SEG_DIGITS[2];
            3'd3:    seg = SEG_DIGITS[3];
            3'd4:    seg = SEG_DIGITS[4];
            default: seg = SEG_E;
        endcase
    end

endmodule : bc_seg_encode
`default_nettype wire

// File: rtl/bc_score_display.sv
`default_nettype none
// ============================================================================
//  Module      : bc_score_display
//  Description : Accepts one (bulls, cows) score over valid/ready and plays it
//                on a single 7-segment display as 'b', bulls, 'c', cows, each
//                held HOLD_CYCLES clocks. A score of four bulls is followed by
//                BLINK_COUNT all-on/all-off pairs.
//  Revision    : 1.0 - initial release
// ============================================================================
module bc_score_display
    import bc_pkg::*;
#(
    parameter int HOLD_CYCLES = 12_000_000,
    parameter int BLINK_COUNT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       res_valid,
    output logic       res_ready,
    input  logic [2:0] bulls,
    input  logic [2:0] cows,
    output logic [7:0] segment_out,
    output logic       busy
);

    localparam int HW = $clog2(HOLD_CYCLES);
    localparam int BW = $clog2(BLINK_COUNT + 1);

    localparam logic [HW-1:0] C_HOLD_LAST  = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] C_HOLD_ONE   = HW'(1);
    localparam logic [BW-1:0] C_BLINK_LAST = BW'(BLINK_COUNT - 1);
    localparam logic [BW-1:0] C_BLINK_ONE  = BW'(1);

    state_t          r_state;
    logic [HW-1:0]   r_hold;
    logic [BW-1:0]   r_blink;
    logic [2:0]      r_bulls;
    logic [2:0]      r_cows;
    logic [7:0]      w_bulls_seg;
    logic [7:0]      w_cows_seg;
    logic            w_accept;
    logic            w_hold_done;

    // Digit codes come from the captured score, which is stable for the
    // whole sequence, so they are ready by the time a digit phase starts.
    bc_seg_encode u_bulls_enc (
        .value (r_bulls),
        .seg   (w_bulls_seg)
    );

    bc_seg_encode u_cows_enc (
        .value (r_cows),
        .seg   (w_cows_seg)
    );

    assign res_ready   = (r_state == IDLE) & ~clear;
    assign busy        = (r_state != IDLE);
    assign w_accept    = res_valid & res_ready;
    assign w_hold_done = (r_hold == C_HOLD_LAST);

    // Sequencer: state, hold/blink counters, capture and registered display.
    // segment_out is loaded alongside each state change so the new code
    // appears on the same edge the phase begins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_hold      <= '0;
            r_blink     <= '0;
            r_bulls     <= '0;
            r_cows      <= '0;
            segment_out <= SEG_DASH;
        end else if (clear) begin
            r_state     <= IDLE;
            r_hold      <= '0;
            r_blink     <= '0;
            segment_out <= SEG_DASH;
        end else if (r_state == IDLE) begin
            r_hold  <= '0;
            r_blink <= '0;
            if (w_accept) begin
                r_bulls     <= bulls;
                r_cows      <= cows;
                r_state     <= SHOW_B;
                segment_out <= SEG_B;
            end
        end else if (!w_hold_done) begin
            r_hold <= r_hold + C_HOLD_ONE;
        end else begin
            r_hold <= '0;
            case (r_state)
                SHOW_B: begin
                    r_state     <= SHOW_BN;
                    segment_out <= w_bulls_seg;
                end
                SHOW_BN: begin
                    r_state     <= SHOW_C;
                    segment_out <= SEG_C;
                end
                SHOW_C: begin
                    r_state     <= SHOW_CN;
                    segment_out <= w_cows_seg;
                end
                SHOW_CN: begin
                    r_blink <= '0;
                    if (r_bulls == 3'd4) begin
                        r_state     <= WIN_ON;
                        segment_out <= SEG_ALL;
                    end else begin
                        r_state     <= IDLE;
                        segment_out <= SEG_DASH;
                    end
                end
                WIN_ON: begin
                    r_state     <= WIN_OFF;
                    segment_out <= SEG_OFF;
                end
                WIN_OFF: begin
                    if (r_blink == C_BLINK_LAST) begin
                        r_blink     <= '0;
                        r_state     <= IDLE;
                        segment_out <= SEG_DASH;
                    end else begin
                        r_blink     <= r_blink + C_BLINK_ONE;
                        r_state     <= WIN_ON;
                        segment_out <= SEG_ALL;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    segment_out <= SEG_DASH;
                end
            endcase
        end
    end

endmodule : bc_score_display
`default_nettype wire

// File: tb/tb_bc_score_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bc_score_display
//  Description : Directed self-checking bench for bc_score_display with
//                HOLD_CYCLES=4 and BLINK_COUNT=2.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bc_score_display;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clear = 1'b0;
    logic       res_valid = 1'b0;
    logic       res_ready;
    logic [2:0] bulls = 3'd0;
    logic [2:0] cows = 3'd0;
    logic [7:0] segment_out;
    logic       busy;

    int checks = 0;
    int fails  = 0;

    bc_score_display #(
        .HOLD_CYCLES (4),
        .BLINK_COUNT (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .bulls       (bulls),
        .cows        (cows),
        .segment_out (segment_out),
        .busy        (busy)
    );

    // 10-unit clock: rising edges at 5,15,..; inputs driven and outputs
    // sampled on falling edges.
    always #5 clk = ~clk;

    task automatic test_reset;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (segment_out !== 8'h40) begin
            fails++;
            $display("FAIL reset_seg: got %h expected 40", segment_out);
        end
        checks++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
        checks++;
        if (res_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready: got %b expected 1", res_ready);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        logic [7:0] e [0:3];
        e[0] = 8'h7C; e[1] = 8'h06; e[2] = 8'h58; e[3] = 8'h5B;
        bulls = 3'd1; cows = 3'd2; res_valid = 1'b1;
        @(negedge clk);
        res_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || res_ready !== 1'b0) begin
            fails++;
            $display("FAIL basic_busy_ready: got busy=%b ready=%b expected 1/0", busy, res_ready);
        end
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (segment_out !== e[i/4]) begin
                fails++;
                $display("FAIL basic_seq[%0d]: got %h expected %h", i, segment_out, e[i/4]);
            end
        end
        checks++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL basic_busy_last: got %b expected 1", busy);
        end
        @(negedge clk);
        checks++;
        if (segment_out !== 8'h40 || busy !== 1'b0) begin
            fails++;
            $display("FAIL basic_end: got seg=%h busy=%b expected 40/0", segment_out, busy);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] e1 [0:3];
        logic [7:0] e2 [0:3];
        e1[0] = 8'h7C; e1[1] = 8'h5B; e1[2] = 8'h58; e1[3] = 8'h06;
        e2[0] = 8'h7C; e2[1] = 8'h4F; e2[2] = 8'h58; e2[3] = 8'h4F;
        @(negedge clk);
        bulls = 3'd2; cows = 3'd1; res_valid = 1'b1;
        @(negedge clk);
        bulls = 3'd3; cows = 3'd3;
        #1;
        checks++;
        if (res_ready !== 1'b0) begin
            fails++;
            $display("FAIL b2b_ready_busy: got %b expected 0", res_ready);
        end
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (segment_out !== e1[i/4]) begin
                fails++;
                $display("FAIL b2b_first[%0d]: got %h expected %h", i, segment_out, e1[i/4]);
            end
        end
        @(negedge clk);
        checks++;
        if (segment_out !== 8'h40 || res_ready !== 1'b1) begin
            fails++;
            $display("FAIL b2b_idle_gap: got seg=%h ready=%b expected 40/1", segment_out, res_ready);
        end
        @(negedge clk);
        res_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (segment_out !== e2[i/4]) begin
                fails++;
                $display("FAIL b2b_second[%0d]: got %h expected %h", i, segment_out, e2[i/4]);
            end
        end
        @(negedge clk);
        checks++;
        if (segment_out !== 8'h40 || busy !== 1'b0) begin
            fails++;
            $display("FAIL b2b_end: got seg=%h busy=%b expected 40/0", segment_out, busy);
        end
    endtask

    task automatic test_win;
        logic [7:0] e [0:7];
        e[0] = 8'h7C; e[1] = 8'h66; e[2] = 8'h58; e[3] = 8'h3F;
        e[4] = 8'hFF; e[5] = 8'h00; e[6] = 8'hFF; e[7] = 8'h00;
        @(negedge clk);
        bulls = 3'd4; cows = 3'd0; res_valid = 1'b1;
        @(negedge clk);
        res_valid = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (segment_out !== e[i/4]) begin
                fails++;
                $display("FAIL win_seq[%0d]: got %h expected %h", i, segment_out, e[i/4]);
            end
        end
        @(negedge clk);
        checks++;
        if (segment_out !== 8'h40 || busy !== 1'b0) begin
            fails++;
            $display("FAIL win_end: got seg=%h busy=%b expected 40/0", segment_out, busy);
        end
    endtask

    task automatic test_error_digits;
        logic [7:0] e [0:3];
        e[0] = 8'h7C; e[1] = 8'h79; e[2] = 8'h58; e[3] = 8'h79;
        @(negedge clk);
        bulls = 3'd5; cows = 3'd7; res_valid = 1'b1;
        @(negedge clk);
        res_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (segment_out !== e[i/4]) begin
                fails++;
                $display("FAIL err_seq[%0d]: got %h expected %h", i, segment_out, e[i/4]);
            end
        end
        @(negedge clk);
        checks++;
        if (segment_out !== 8'h40 || busy !== 1'b0) begin
            fails++;
            $display("FAIL err_end: got seg=%h busy=%b expected 40/0", segment_out, busy);
        end
    endtask

    task automatic test_clear_and_rst;
        // clear during SHOW_C
        @(negedge clk);
        bulls = 3'd1; cows = 3'd1; res_valid = 1'b1;
        @(negedge clk);
        res_valid = 1'b0;
        for (int i = 1; i < 10; i++) @(negedge clk);
        checks++;
        if (segment_out !== 8'h58) begin
            fails++;
            $display("FAIL clr_in_showc: got %h expected 58", segment_out);
        end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        #1;
        checks++;
        if (segment_out !== 8'h40 || res_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL clr_abort: got seg=%h ready=%b busy=%b expected 40/1/0",
                     segment_out, res_ready, busy);
        end
        // clear together with valid in IDLE: nothing accepted
        @(negedge clk);
        clear = 1'b1; res_valid = 1'b1; bulls = 3'd2;
        #1;
        checks++;
        if (res_ready !== 1'b0) begin
            fails++;
            $display("FAIL clr_ready_low: got %b expected 0", res_ready);
        end
        @(negedge clk);
        checks++;
        if (segment_out !== 8'h40 || busy !== 1'b0) begin
            fails++;
            $display("FAIL clr_no_accept: got seg=%h busy=%b expected 40/0", segment_out, busy);
        end
        clear = 1'b0; res_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (segment_out !== 8'h40 || busy !== 1'b0) begin
            fails++;
            $display("FAIL clr_still_idle: got seg=%h busy=%b expected 40/0", segment_out, busy);
        end
        // async reset during WIN_ON
        bulls = 3'd4; cows = 3'd4; res_valid = 1'b1;
        @(negedge clk);
        res_valid = 1'b0;
        for (int i = 1; i < 18; i++) @(negedge clk);
        checks++;
        if (segment_out !== 8'hFF) begin
            fails++;
            $display("FAIL rst_in_winon: got %h expected FF", segment_out);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (segment_out !== 8'h40 || busy !== 1'b0 || res_ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_async: got seg=%h busy=%b ready=%b expected 40/0/1",
                     segment_out, busy, res_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (segment_out !== 8'h40 || busy !== 1'b0) begin
            fails++;
            $display("FAIL rst_no_resume: got seg=%h busy=%b expected 40/0", segment_out, busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_win();
        test_error_digits();
        test_clear_and_rst();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule : tb_bc_score_display
`default_nettype wire
